dac_sample_feeder: RTL

DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

---
 rtl/dac_sample_feeder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dac_sample_feeder.sv
`default_nettype none
// dac_sample_feeder -- timer-paced sample FIFO feeding an SPI DAC driver start/done handshake.
// Rev 1.0
module dac_sample_feeder #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 16
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [15:0]            rate_div,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   clr_flags,
   input  logic                   dac_done,
   output logic                   dac_start,
   output logic [DATA_W-1:0]      dac_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   underrun,
   output logic                   overflow,
   output logic                   missed,
   output logic [15:0]            sample_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   C_FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_ACK     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         level_q, level_d;
   logic                full_q, empty_q;
   logic                dac_start_q;
   logic [DATA_W-1:0]   dac_data_q, dac_data_d;
   logic                under_q, over_q, missed_q;
   logic [15:0]         count_q, count_d;
   logic                done_prev_q;

   logic tick, pop, push, done_rise;
   logic under_ev, over_ev, missed_ev;

   assign tick      = enable && (cnt_q == rate_div);
   assign cnt_d     = (!enable || tick) ? 16'd0 : cnt_q + 16'd1;
   assign done_rise = dac_done && !done_prev_q;

   always_comb begin
      state_d    = state_q;
      dac_data_d = dac_data_q;
      count_d    = count_q;
      pop        = 1'b0;
      under_ev   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               if (!empty_q) begin
                  pop        = 1'b1;
                  dac_data_d = mem_q[rd_ptr_q];
                  state_d    = S_START;
               end else begin
                  under_ev   = 1'b1;
               end
            end
         end
         S_START: begin
            if (done_rise) begin
               state_d = S_ACK;
               count_d = count_q + 16'd1;
            end
         end
         S_ACK: begin
            if (!dac_done) state_d = S_RELEASE;
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push      = wr_en && (!full_q || pop);
   assign over_ev   = wr_en && full_q && !pop;
   assign missed_ev = tick && (state_q != S_IDLE);

   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + C_LVL_ONE;
      else if (pop && !push) level_d = level_q - C_LVL_ONE;
   end

   always_ff @(posedge sys_clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         dac_start_q <= 1'b0;
         dac_data_q  <= '0;
         under_q     <= 1'b0;
         over_q      <= 1'b0;
         missed_q    <= 1'b0;
         count_q     <= 16'd0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
         level_q     <= level_d;
         full_q      <= (level_d == C_FULL_LVL);
         empty_q     <= (level_d == '0);
         dac_start_q <= (state_d == S_START);
         dac_data_q  <= dac_data_d;
         // A flag event in the same cycle as clr_flags leaves the flag set.
         under_q     <= (under_q  && !clr_flags) || under_ev;
         over_q      <= (over_q   && !clr_flags) || over_ev;
         missed_q    <= (missed_q && !clr_flags) || missed_ev;
         count_q     <= count_d;
         done_prev_q <= dac_done;
      end
   end

   assign dac_start    = dac_start_q;
   assign dac_data     = dac_data_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign level        = level_q;
   assign underrun     = under_q;
   assign overflow     = over_q;
   assign missed       = missed_q;
   assign sample_count = count_q;
endmodule
`default_nettype wire
